// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader
// Serial-to-parallel operand loader for the GEMM core. It accepts a word stream
// in this order: alpha, beta, A, B, C, with each matrix in row-major order.
// It assembles the stream into parallel operands and holds them, with
// out_valid high, until the core returns out_ack.
// Optional feature macro: GEMM_LOADER_LAST_CHECK_EN enables in_last framing
// checks and the frame_err pulse. When the macro is undefined, in_last is
// ignored and frame_err stays 0.
module gemm_operand_loader #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] alpha,
    output logic [DATA_WIDTH-1:0] beta,
    output logic [DATA_WIDTH-1:0] a_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic [DATA_WIDTH-1:0] b_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic [DATA_WIDTH-1:0] c_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  frame_err
);

    localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int COL_W = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_WIDTH - 1);

    typedef enum logic [2:0] {
        S_ALPHA = 3'd0,
        S_BETA  = 3'd1,
        S_A     = 3'd2,
        S_B     = 3'd3,
        S_C     = 3'd4,
        S_FULL  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      w_row_next;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      w_col_next;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_frame_err;
    logic                  w_err_next;
    logic                  w_accept;
    logic                  w_last_elem;
    logic                  w_final_word;

    logic [DATA_WIDTH-1:0] r_alpha;
    logic [DATA_WIDTH-1:0] r_beta;
    logic [DATA_WIDTH-1:0] r_a [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] r_b [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] r_c [MATRIX_HEIGHT][MATRIX_WIDTH];

    assign w_accept     = in_valid && r_in_ready;
    assign w_last_elem  = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_final_word = (r_state == S_C) && w_last_elem;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign alpha     = r_alpha;
    assign beta      = r_beta;
    assign a_matrix  = r_a;
    assign b_matrix  = r_b;
    assign c_matrix  = r_c;

`ifndef GEMM_LOADER_LAST_CHECK_EN
    logic w_unused_last;
    assign w_unused_last = in_last;
`endif

    // FSM state, element counters and handshake flags
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state     <= S_ALPHA;
            r_row       <= '0;
            r_col       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            // Ready is dropped on the edge that takes the final word, so
            // nothing can be accepted while the frame is on offer.
            r_in_ready  <= (w_state_next != S_FULL);
            r_out_valid <= (w_state_next == S_FULL);
            r_frame_err <= w_err_next;
        end
    end

    // Next-state, row/col walk through each matrix, and framing-error detection
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_err_next   = 1'b0;
        case (r_state)
            S_ALPHA: if (w_accept) w_state_next = S_BETA;
            S_BETA:  if (w_accept) w_state_next = S_A;
            S_A, S_B, S_C: begin
                if (w_accept) begin
                    if (w_last_elem) begin
                        w_row_next = '0;
                        w_col_next = '0;
                        if (r_state == S_A)      w_state_next = S_B;
                        else if (r_state == S_B) w_state_next = S_C;
                        else                     w_state_next = S_FULL;
                    end else if (r_col == COL_LAST) begin
                        w_col_next = '0;
                        w_row_next = r_row + ROW_W'(1);
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
            S_FULL:  if (out_ack) w_state_next = S_ALPHA;
            default: begin
                w_state_next = S_ALPHA;
                w_row_next   = '0;
                w_col_next   = '0;
            end
        endcase
`ifdef GEMM_LOADER_LAST_CHECK_EN
        // An early in_last abandons the partial frame. A missing in_last on
        // the final word is flagged, but the frame is still delivered.
        if (w_accept && in_last && !w_final_word) begin
            w_state_next = S_ALPHA;
            w_row_next   = '0;
            w_col_next   = '0;
            w_err_next   = 1'b1;
        end else if (w_accept && w_final_word && !in_last) begin
            w_err_next   = 1'b1;
        end
`endif
    end

    // Scalar operand capture; each accepted word lands only in its own register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_alpha <= '0;
            r_beta  <= '0;
        end else if (w_accept) begin
            if (r_state == S_ALPHA) r_alpha <= in_data;
            if (r_state == S_BETA)  r_beta  <= in_data;
        end
    end

    // Matrix operand capture at the current row/col of the active matrix
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
                for (int c = 0; c < MATRIX_WIDTH; c++) begin
                    r_a[r][c] <= '0;
                    r_b[r][c] <= '0;
                    r_c[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            case (r_state)
                S_A:     r_a[r_row][r_col] <= in_data;
                S_B:     r_b[r_row][r_col] <= in_data;
                S_C:     r_c[r_row][r_col] <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Testbench for gemm_operand_loader. A scoreboard queue collects every word the
// bench streams in. When out_valid rises, the queue is drained against the
// operand outputs.
module tb_gemm_operand_loader;

    localparam int DW = 64;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int N  = 2 + 3 * H * W;

    logic          iclk;
    logic          irst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] alpha;
    logic [DW-1:0] beta;
    logic [DW-1:0] a_matrix [H][W];
    logic [DW-1:0] b_matrix [H][W];
    logic [DW-1:0] c_matrix [H][W];
    logic          out_valid;
    logic          out_ack;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [DW-1:0] exp_q [$];

    gemm_operand_loader #(
        .DATA_WIDTH   (DW),
        .MATRIX_HEIGHT(H),
        .MATRIX_WIDTH (W)
    ) dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .alpha    (alpha),
        .beta     (beta),
        .a_matrix (a_matrix),
        .b_matrix (b_matrix),
        .c_matrix (c_matrix),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .frame_err(frame_err)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc = cyc + 1;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Offer one word until it is taken; the expected value is queued on drive.
    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gaps);
        int   guard;
        logic rdy;
        bit   taken;
        if (gaps) begin
            for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        exp_q.push_back(d);
        guard = 0;
        taken = 1'b0;
        while (!taken && guard < 100) begin
            rdy = in_ready;
            tick();
            taken = rdy;
            guard++;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0d not taken, in_ready=%b required 1", d, in_ready);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int nwords, input bit gaps,
                              input int last_pos, input bit ack_mid);
        for (int i = 1; i <= nwords; i++) begin
            out_ack = ack_mid && (i >= 5) && (i <= 40);
            send_word(base + DW'(i), (i == last_pos), gaps);
        end
        out_ack = 1'b0;
    endtask

    // Drain one frame from the scoreboard and compare it against every operand.
    task automatic check_frame(input string name);
        logic [DW-1:0] e;
        if (exp_q.size() != N) begin
            checks++;
            errors++;
            $display("FAIL %s_queue: got %0d words required %0d", name, exp_q.size(), N);
        end
        if (exp_q.size() >= N) begin
            e = exp_q.pop_front();
            checks++;
            if (alpha !== e) begin errors++; $display("FAIL %s_alpha: got %0d required %0d", name, alpha, e); end
            e = exp_q.pop_front();
            checks++;
            if (beta !== e) begin errors++; $display("FAIL %s_beta: got %0d required %0d", name, beta, e); end
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
                e = exp_q.pop_front();
                checks++;
                if (a_matrix[r][c] !== e) begin errors++; $display("FAIL %s_a[%0d][%0d]: got %0d required %0d", name, r, c, a_matrix[r][c], e); end
            end
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
                e = exp_q.pop_front();
                checks++;
                if (b_matrix[r][c] !== e) begin errors++; $display("FAIL %s_b[%0d][%0d]: got %0d required %0d", name, r, c, b_matrix[r][c], e); end
            end
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
                e = exp_q.pop_front();
                checks++;
                if (c_matrix[r][c] !== e) begin errors++; $display("FAIL %s_c[%0d][%0d]: got %0d required %0d", name, r, c, c_matrix[r][c], e); end
            end
        end
        exp_q.delete();
    endtask

    task automatic do_ack(input string name);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_ack: out_valid,in_ready=%b required 01", name, {out_valid, in_ready});
        end
    endtask

    task automatic test_reset();
        irst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({in_ready, out_valid, frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {in_ready, out_valid, frame_err});
        end
        checks++;
        if (alpha !== '0 || beta !== '0 || a_matrix[0][0] !== '0 || b_matrix[2][1] !== '0 || c_matrix[3][3] !== '0) begin
            errors++; $display("FAIL reset_operands: alpha=%0d beta=%0d c33=%0d required 0", alpha, beta, c_matrix[3][3]);
        end
        irst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b required 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b required 1", in_ready); end
    endtask

    task automatic test_continuous();
        int start;
        start = cyc;
        send_frame(0, N - 1, 1'b0, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL cont_early_valid: got %b required 0", out_valid); end
        send_word(DW'(N), 1'b1, 1'b0);
        checks++;
        if (cyc - start !== N) begin errors++; $display("FAIL cont_throughput: took %0d cycles required %0d", cyc - start, N); end
        checks++;
        if ({out_valid, in_ready, frame_err} !== 3'b100) begin
            errors++; $display("FAIL cont_flags: out_valid,in_ready,frame_err=%b required 100", {out_valid, in_ready, frame_err});
        end
        checks++;
        if (alpha !== 1 || beta !== 2 || a_matrix[0][0] !== 3 || a_matrix[3][3] !== 18 || b_matrix[0][0] !== 19 || c_matrix[3][3] !== 50) begin
            errors++; $display("FAIL cont_spot: alpha=%0d beta=%0d a00=%0d a33=%0d b00=%0d c33=%0d required 1 2 3 18 19 50",
                               alpha, beta, a_matrix[0][0], a_matrix[3][3], b_matrix[0][0], c_matrix[3][3]);
        end
        check_frame("cont");
    endtask

    task automatic test_hold_full();
        in_data  = 64'hDEAD;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b10) begin
                errors++; $display("FAIL hold_flags_%0d: out_valid,in_ready=%b required 10", i, {out_valid, in_ready});
            end
        end
        in_valid = 1'b0;
        checks++;
        if (alpha !== 1 || c_matrix[3][3] !== 50 || b_matrix[0][0] !== 19) begin
            errors++; $display("FAIL hold_operands: alpha=%0d c33=%0d b00=%0d required 1 50 19", alpha, c_matrix[3][3], b_matrix[0][0]);
        end
        do_ack("hold");
        checks++;
        if (alpha !== 1 || c_matrix[3][3] !== 50) begin
            errors++; $display("FAIL hold_after_ack: alpha=%0d c33=%0d required 1 50", alpha, c_matrix[3][3]);
        end
    endtask

    task automatic test_random_valid();
        send_frame(100, N, 1'b1, N, 1'b1);
        checks++;
        if ({out_valid, in_ready, frame_err} !== 3'b100) begin
            errors++; $display("FAIL rand_flags: out_valid,in_ready,frame_err=%b required 100", {out_valid, in_ready, frame_err});
        end
        check_frame("rand");
        do_ack("rand");
    endtask

    task automatic test_reset_midframe();
        send_frame(200, 20, 1'b0, 0, 1'b0);
        irst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, frame_err} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags: got %b required 000", {in_ready, out_valid, frame_err});
        end
        checks++;
        if (alpha !== '0 || beta !== '0 || a_matrix[0][0] !== '0 || a_matrix[3][1] !== '0) begin
            errors++; $display("FAIL midrst_operands: alpha=%0d beta=%0d a00=%0d a31=%0d required 0", alpha, beta, a_matrix[0][0], a_matrix[3][1]);
        end
        exp_q.delete();
        repeat (2) tick();
        irst_n = 1'b1;
        tick();
        send_frame(300, N, 1'b0, N, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b required 1", out_valid); end
        check_frame("midrst");
        do_ack("midrst");
    endtask

`ifdef GEMM_LOADER_LAST_CHECK_EN
    task automatic test_last_early();
        send_frame(400, 10, 1'b0, 10, 1'b0);
        checks++;
        if ({frame_err, out_valid, in_ready} !== 3'b101) begin
            errors++; $display("FAIL early_flags: frame_err,out_valid,in_ready=%b required 101", {frame_err, out_valid, in_ready});
        end
        tick();
        checks++;
        if ({frame_err, out_valid} !== 2'b00) begin
            errors++; $display("FAIL early_pulse: frame_err,out_valid=%b required 00", {frame_err, out_valid});
        end
        exp_q.delete();
        send_frame(500, N, 1'b0, N, 1'b0);
        checks++;
        if ({out_valid, frame_err} !== 2'b10) begin
            errors++; $display("FAIL early_next_flags: out_valid,frame_err=%b required 10", {out_valid, frame_err});
        end
        check_frame("early_next");
        do_ack("early_next");
    endtask

    task automatic test_last_missing();
        send_frame(600, N, 1'b0, 0, 1'b0);
        checks++;
        if ({frame_err, out_valid} !== 2'b11) begin
            errors++; $display("FAIL missing_flags: frame_err,out_valid=%b required 11", {frame_err, out_valid});
        end
        tick();
        checks++;
        if ({frame_err, out_valid} !== 2'b01) begin
            errors++; $display("FAIL missing_pulse: frame_err,out_valid=%b required 01", {frame_err, out_valid});
        end
        check_frame("missing");
        do_ack("missing");
    endtask
`else
    task automatic test_last_ignored();
        send_frame(700, N, 1'b0, 10, 1'b0);
        checks++;
        if ({out_valid, frame_err} !== 2'b10) begin
            errors++; $display("FAIL ignored_flags: out_valid,frame_err=%b required 10", {out_valid, frame_err});
        end
        check_frame("ignored");
        do_ack("ignored");
    endtask
`endif

    initial begin
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        irst_n   = 1'b0;
        test_reset();
        test_continuous();
        test_hold_full();
        test_random_valid();
        test_reset_midframe();
`ifdef GEMM_LOADER_LAST_CHECK_EN
        test_last_early();
        test_last_missing();
`else
        test_last_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
